// File: rtl/pipeline_control_if.sv
// Pipeline sequencer bundle: hazard/status inputs from the stage modules
// and enable/valid/forward/status outputs back to them.
interface pipeline_control_if #(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5
);
    logic                  i_FetchValid;
    logic [REG_ADDR_W-1:0] i_ID_Rs1;
    logic [REG_ADDR_W-1:0] i_ID_Rs2;
    logic                  i_ID_UsesRs1;
    logic                  i_ID_UsesRs2;
    logic [REG_ADDR_W-1:0] i_EX_Rs1;
    logic [REG_ADDR_W-1:0] i_EX_Rs2;
    logic [REG_ADDR_W-1:0] i_EX_Rd;
    logic                  i_EX_RegWrite;
    logic                  i_EX_IsLoad;
    logic [REG_ADDR_W-1:0] i_MEM_Rd;
    logic                  i_MEM_RegWrite;
    logic [REG_ADDR_W-1:0] i_WB_Rd;
    logic                  i_WB_RegWrite;
    logic                  i_MEM_Busy;
    logic                  i_Redirect;

    logic                  o_PCEnable;
    logic [NUM_STAGES-1:0] o_StageEnable;
    logic [NUM_STAGES-1:0] o_StageValid;
    logic [1:0]            o_FwdA;
    logic [1:0]            o_FwdB;
    logic                  o_Stall;
    logic                  o_MemTimeout;
    logic [31:0]           o_RetiredCount;
    logic [31:0]           o_StallCycles;

    // Sequencer side
    modport master (
        input  i_FetchValid, i_ID_Rs1, i_ID_Rs2, i_ID_UsesRs1, i_ID_UsesRs2,
        input  i_EX_Rs1, i_EX_Rs2, i_EX_Rd, i_EX_RegWrite, i_EX_IsLoad,
        input  i_MEM_Rd, i_MEM_RegWrite, i_WB_Rd, i_WB_RegWrite,
        input  i_MEM_Busy, i_Redirect,
        output o_PCEnable, o_StageEnable, o_StageValid, o_FwdA, o_FwdB,
        output o_Stall, o_MemTimeout, o_RetiredCount, o_StallCycles
    );

    // Datapath / stage side
    modport slave (
        output i_FetchValid, i_ID_Rs1, i_ID_Rs2, i_ID_UsesRs1, i_ID_UsesRs2,
        output i_EX_Rs1, i_EX_Rs2, i_EX_Rd, i_EX_RegWrite, i_EX_IsLoad,
        output i_MEM_Rd, i_MEM_RegWrite, i_WB_Rd, i_WB_RegWrite,
        output i_MEM_Busy, i_Redirect,
        input  o_PCEnable, o_StageEnable, o_StageValid, o_FwdA, o_FwdB,
        input  o_Stall, o_MemTimeout, o_RetiredCount, o_StallCycles
    );
endinterface

// File: rtl/pipeline_control.sv
// Pipeline sequencer: stage valids/enables, interlocks, forwarding, MEM hang watch.
// Optional perf counters built when PIPELINE_PERF_COUNTERS_EN is defined.
module pipeline_control #(
    parameter int NUM_STAGES  = 5,
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    pipeline_control_if.master   bus
);
    localparam int LAST = NUM_STAGES - 1;
    localparam int MEMS = NUM_STAGES - 2;
    localparam int TW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

    logic [NUM_STAGES-1:1] vld_q;
    logic [NUM_STAGES-1:0] vld;
    logic                  busy;
    logic                  redirect;
    logic                  hazard;
    logic                  load_use;
    logic                  stall;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic                  mem_ok;
    logic                  wb_ok;
    logic [NUM_STAGES-1:0] en;
    logic                  pc_en;
    logic [TW-1:0]         to_cnt;
    logic [TW-1:0]         to_nxt;
    logic                  to_flag;

    assign vld = {vld_q, bus.i_FetchValid};

    // A busy MEM stage overrides everything; redirect then beats load-use.
    assign busy     = bus.i_MEM_Busy;
    assign redirect = ~busy & bus.i_Redirect & vld[2];

    assign rs1_hit = bus.i_ID_UsesRs1 & (bus.i_ID_Rs1 == bus.i_EX_Rd);
    assign rs2_hit = bus.i_ID_UsesRs2 & (bus.i_ID_Rs2 == bus.i_EX_Rd);
    assign hazard  = vld[1] & vld[2] & bus.i_EX_IsLoad & bus.i_EX_RegWrite
                   & (|bus.i_EX_Rd) & (rs1_hit | rs2_hit);
    assign load_use = hazard & ~busy & ~redirect;
    assign stall    = busy | load_use;

    // Combinational load enables for PC and the inter-stage registers.
    always_comb begin
        en    = '1;
        pc_en = 1'b1;
        unique case (1'b1)
            busy: begin
                en[LAST-1:0] = '0;
                pc_en        = 1'b0;
            end
            load_use: begin
                en[1:0] = 2'b00;
                pc_en   = 1'b0;
            end
            default: ;
        endcase
    end

    // Stage valid bits: hold, squash or shift depending on the cycle's event.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            vld_q <= '0;
        end else begin
            unique case (1'b1)
                busy: begin
                    vld_q[LAST] <= 1'b0;
                end
                redirect: begin
                    vld_q[1] <= 1'b0;
                    vld_q[2] <= 1'b0;
                    for (int k = 3; k < NUM_STAGES; k++)
                        vld_q[k] <= vld[k-1];
                end
                load_use: begin
                    vld_q[2] <= 1'b0;
                    for (int k = 3; k < NUM_STAGES; k++)
                        vld_q[k] <= vld[k-1];
                end
                default: begin
                    for (int k = 1; k < NUM_STAGES; k++)
                        vld_q[k] <= vld[k-1];
                end
            endcase
        end
    end

    // EX operand bypass: the younger MEM result wins over WB.
    assign mem_ok = vld[MEMS] & bus.i_MEM_RegWrite & (|bus.i_MEM_Rd);
    assign wb_ok  = vld[LAST] & bus.i_WB_RegWrite & (|bus.i_WB_Rd);

    assign bus.o_FwdA = (mem_ok && bus.i_MEM_Rd == bus.i_EX_Rs1) ? 2'b01 :
                        (wb_ok  && bus.i_WB_Rd  == bus.i_EX_Rs1) ? 2'b10 :
                                                                   2'b00;
    assign bus.o_FwdB = (mem_ok && bus.i_MEM_Rd == bus.i_EX_Rs2) ? 2'b01 :
                        (wb_ok  && bus.i_WB_Rd  == bus.i_EX_Rs2) ? 2'b10 :
                                                                   2'b00;

    assign to_nxt = (to_cnt == TMAX) ? to_cnt : to_cnt + 1'b1;

    // Saturating busy-run counter with a sticky hang flag.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (busy) begin
            to_cnt <= to_nxt;
            if (to_nxt == TMAX)
                to_flag <= 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

`ifdef PIPELINE_PERF_COUNTERS_EN
    logic [31:0] ret_q;
    logic [31:0] stl_q;

    // Free-running retire and stall counters, wrapping at 2^32.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ret_q <= '0;
            stl_q <= '0;
        end else begin
            ret_q <= ret_q + {31'd0, vld[LAST]};
            stl_q <= stl_q + {31'd0, stall};
        end
    end

    assign bus.o_RetiredCount = ret_q;
    assign bus.o_StallCycles  = stl_q;
`else
    assign bus.o_RetiredCount = '0;
    assign bus.o_StallCycles  = '0;
`endif

    assign bus.o_PCEnable    = pc_en;
    assign bus.o_StageEnable = en;
    assign bus.o_StageValid  = vld;
    assign bus.o_Stall       = stall;
    assign bus.o_MemTimeout  = to_flag;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control (N=5, MEM_TIMEOUT=4) with an
// expected-value queue; counter checks adapt to PIPELINE_PERF_COUNTERS_EN.
module tb_pipeline_control;
`ifdef PIPELINE_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;

    pipeline_control_if #(.NUM_STAGES(5), .REG_ADDR_W(5)) bus ();

    pipeline_control #(
        .NUM_STAGES (5),
        .REG_ADDR_W (5),
        .MEM_TIMEOUT(4)
    ) dut (
        .i_Clock  (clk),
        .i_Reset_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   passed;
    int   failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic got(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            failed++;
            $error("FAIL sb_empty: observed %0h, no expectation queued", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic clear_inputs();
        bus.i_ID_Rs1       = '0;
        bus.i_ID_Rs2       = '0;
        bus.i_ID_UsesRs1   = 1'b0;
        bus.i_ID_UsesRs2   = 1'b0;
        bus.i_EX_Rs1       = '0;
        bus.i_EX_Rs2       = '0;
        bus.i_EX_Rd        = '0;
        bus.i_EX_RegWrite  = 1'b0;
        bus.i_EX_IsLoad    = 1'b0;
        bus.i_MEM_Rd       = '0;
        bus.i_MEM_RegWrite = 1'b0;
        bus.i_WB_Rd        = '0;
        bus.i_WB_RegWrite  = 1'b0;
        bus.i_MEM_Busy     = 1'b0;
        bus.i_Redirect     = 1'b0;
    endtask

    task automatic drive_load_use(input logic [4:0] rd);
        bus.i_EX_IsLoad   = 1'b1;
        bus.i_EX_RegWrite = 1'b1;
        bus.i_EX_Rd       = rd;
        bus.i_ID_Rs2      = rd;
        bus.i_ID_UsesRs2  = 1'b1;
    endtask

    initial begin
        logic [4:0] pat;
        total  = 0;
        passed = 0;
        failed = 0;
        rst_n  = 1'b0;
        clear_inputs();
        bus.i_FetchValid = 1'b1;
        #1;

        // Reset state
        expect_v("rst_valid", 32'h01);
        got(bus.o_StageValid);
        expect_v("rst_timeout", 32'h0);
        got(bus.o_MemTimeout);
        expect_v("rst_retired", 32'h0);
        got(bus.o_RetiredCount);
        expect_v("rst_stalls", 32'h0);
        got(bus.o_StallCycles);

        ticks(2);
        rst_n = 1'b1;

        // Pipeline fill
        for (int i = 0; i < 5; i++) begin
            pat = 5'((32'd1 << (i + 1)) - 1);
            expect_v($sformatf("fill_%0d", i), {27'd0, pat});
            got(bus.o_StageValid);
            tick();
        end
        expect_v("fill_full", 32'h1f);
        got(bus.o_StageValid);
        expect_v("retired_first", PERF ? 32'd1 : 32'd0);
        got(bus.o_RetiredCount);

        // Load-use on Rs2
        drive_load_use(5'd5);
        #1;
        expect_v("lu_en", 32'h1c);
        got(bus.o_StageEnable);
        expect_v("lu_pc", 32'h0);
        got(bus.o_PCEnable);
        expect_v("lu_stall", 32'h1);
        got(bus.o_Stall);
        tick();
        clear_inputs();
        expect_v("lu_valid", 32'h1b);
        got(bus.o_StageValid);
        expect_v("lu_stallcnt", PERF ? 32'd1 : 32'd0);
        got(bus.o_StallCycles);
        ticks(3);
        expect_v("lu_refill", 32'h1f);
        got(bus.o_StageValid);

        // Load to x0 never interlocks
        drive_load_use(5'd0);
        #1;
        expect_v("lu_x0_stall", 32'h0);
        got(bus.o_Stall);
        expect_v("lu_x0_pc", 32'h1);
        got(bus.o_PCEnable);
        expect_v("lu_x0_en", 32'h1f);
        got(bus.o_StageEnable);
        clear_inputs();

        // Redirect squashes IF and ID
        bus.i_Redirect = 1'b1;
        #1;
        expect_v("rd_pc", 32'h1);
        got(bus.o_PCEnable);
        expect_v("rd_stall", 32'h0);
        got(bus.o_Stall);
        tick();
        bus.i_Redirect = 1'b0;
        #1;
        expect_v("rd_valid", 32'h19);
        got(bus.o_StageValid);
        ticks(4);

        // Redirect beats load-use in the same cycle
        bus.i_Redirect = 1'b1;
        drive_load_use(5'd5);
        #1;
        expect_v("rdlu_stall", 32'h0);
        got(bus.o_Stall);
        expect_v("rdlu_pc", 32'h1);
        got(bus.o_PCEnable);
        expect_v("rdlu_en", 32'h1f);
        got(bus.o_StageEnable);
        tick();
        clear_inputs();
        #1;
        expect_v("rdlu_valid", 32'h19);
        got(bus.o_StageValid);
        ticks(4);

        // MEM busy for 3 cycles, redirect raised during the freeze
        for (int c = 0; c < 3; c++) begin
            bus.i_MEM_Busy = 1'b1;
            if (c >= 1) bus.i_Redirect = 1'b1;
            #1;
            expect_v($sformatf("busy_en_%0d", c), 32'h10);
            got(bus.o_StageEnable);
            expect_v($sformatf("busy_pc_%0d", c), 32'h0);
            got(bus.o_PCEnable);
            expect_v($sformatf("busy_stall_%0d", c), 32'h1);
            got(bus.o_Stall);
            tick();
            expect_v($sformatf("busy_valid_%0d", c), 32'h0f);
            got(bus.o_StageValid);
        end
        expect_v("busy3_timeout", 32'h0);
        got(bus.o_MemTimeout);
        bus.i_MEM_Busy = 1'b0;
        #1;
        expect_v("held_rd_pc", 32'h1);
        got(bus.o_PCEnable);
        expect_v("held_rd_stall", 32'h0);
        got(bus.o_Stall);
        tick();
        bus.i_Redirect = 1'b0;
        #1;
        expect_v("held_rd_valid", 32'h19);
        got(bus.o_StageValid);
        expect_v("busy_stallcnt", PERF ? 32'd4 : 32'd0);
        got(bus.o_StallCycles);
        ticks(4);

        // Busy for 6 cycles trips the hang flag after the 4th
        for (int c = 0; c < 6; c++) begin
            bus.i_MEM_Busy = 1'b1;
            tick();
            expect_v($sformatf("to_cycle_%0d", c), (c >= 3) ? 32'h1 : 32'h0);
            got(bus.o_MemTimeout);
        end
        bus.i_MEM_Busy = 1'b0;
        tick();
        expect_v("to_sticky", 32'h1);
        got(bus.o_MemTimeout);
        expect_v("to_stallcnt", PERF ? 32'd10 : 32'd0);
        got(bus.o_StallCycles);

        // Reset clears everything
        rst_n = 1'b0;
        #1;
        expect_v("rst2_timeout", 32'h0);
        got(bus.o_MemTimeout);
        expect_v("rst2_valid", 32'h01);
        got(bus.o_StageValid);
        expect_v("rst2_stalls", 32'h0);
        got(bus.o_StallCycles);
        tick();
        rst_n = 1'b1;
        ticks(4);
        expect_v("rst2_refill", 32'h1f);
        got(bus.o_StageValid);

        // Forwarding
        bus.i_MEM_Rd       = 5'd7;
        bus.i_WB_Rd        = 5'd7;
        bus.i_EX_Rs1       = 5'd7;
        bus.i_EX_Rs2       = 5'd9;
        bus.i_MEM_RegWrite = 1'b1;
        bus.i_WB_RegWrite  = 1'b1;
        #1;
        expect_v("fwd_mem_a", 32'h1);
        got(bus.o_FwdA);
        expect_v("fwd_none_b", 32'h0);
        got(bus.o_FwdB);
        bus.i_MEM_RegWrite = 1'b0;
        #1;
        expect_v("fwd_wb_a", 32'h2);
        got(bus.o_FwdA);
        bus.i_WB_Rd = 5'd9;
        #1;
        expect_v("fwd_wb_b", 32'h2);
        got(bus.o_FwdB);
        expect_v("fwd_miss_a", 32'h0);
        got(bus.o_FwdA);
        bus.i_MEM_Rd       = 5'd0;
        bus.i_WB_Rd        = 5'd0;
        bus.i_EX_Rs1       = 5'd0;
        bus.i_MEM_RegWrite = 1'b1;
        #1;
        expect_v("fwd_x0_a", 32'h0);
        got(bus.o_FwdA);
        clear_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
